pipe_skid_reg: RTL and testbench
================================

Name: pipe_skid_reg

Overview:
- Parametrised successor of the fixed MEM2→WB stage register.
- Carries a bundle of LANES payloads, each WIDTH bits wide, with a per-lane valid bit, for dual-issue stage boundaries.
- Replaces the plain write-enable stall with a valid/ready handshake and a 2-entry skid buffer, so backpressure is fully registered and a full bundle can be accepted every cycle.
- Provides flush and an occupancy output. Instantiated at every stage boundary from MEM1→MEM2 onwards.

Parameters:
- WIDTH, 32, payload bits per lane (PC, result, dst, regs-write type packed by the instantiating stage).
- LANES, 2, issue lanes per bundle (≥1).
- CLEAR_DATA, 1, when 1 the payload of invalid lanes and all flushed/reset slots is forced to 0; when 0 only valid bits are cleared.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  discards all held and incoming bundles.
- in_valid  in  LANES  per-lane valid of upstream bundle.
- in_data  in  LANES*WIDTH  lane i at bits [i*WIDTH +: WIDTH].
- in_ready  out  1  stage can accept a bundle; driven from a register only.
- out_valid  out  LANES  per-lane valid of head bundle.
- out_data  out  LANES*WIDTH  head bundle payload.
- out_ready  in  1  downstream consumes head bundle.
- occ  out  2  bundles held (0..2).

Behaviour:
- Bundle-valid definitions:
  - in_any = |in_valid; in_fire = in_any & in_ready.
  - out_any = |out_valid; out_fire = out_any & out_ready.
- Lanes move together as one bundle; a bundle is never split.
- Storage: head slot (drives out_*) and skid slot. State enum: S_EMPTY, S_FULL, S_SKID.
- Priority: rst > flush > handshake.
- Reset, registered on the next clk edge:
  - state = S_EMPTY, out_valid = 0, out_data = 0, skid = 0, occ = 0, in_ready = 1.
- Flush:
  - Next state is S_EMPTY with all valids 0. Data is 0 if CLEAR_DATA, else held.
  - An input presented in the flush cycle is dropped even if in_ready = 1.
  - out_fire in the flush cycle is still counted by downstream; the flush controller owns that ordering.
- Transitions (no flush):
  - S_EMPTY:
    - in_fire → S_FULL, head ← in.
  - S_FULL:
    - in_fire & out_fire → S_FULL, head ← in.
    - in_fire & !out_fire → S_SKID, skid ← in.
    - !in_fire & out_fire → S_EMPTY.
    - otherwise hold.
  - S_SKID:
    - in_ready = 0, so no in_fire is possible.
    - out_fire → S_FULL, head ← skid.
    - otherwise hold.
- in_ready is registered: 1 in S_EMPTY and S_FULL, 0 in S_SKID. It is never a combinational function of out_ready.
- Latency and throughput:
  - Latency in→out is 1 cycle.
  - Sustained throughput is 1 bundle/cycle with out_ready held high.
  - No bubble is inserted on resume from S_SKID.
- in_valid = 0 on all lanes is not a bundle; it is never stored and never changes state.
- With CLEAR_DATA = 1, an invalid lane's payload is stored as 0 on capture.
- occ: S_EMPTY = 0, S_FULL = 1, S_SKID = 2. Registered, same edge as the state.
- Ordering: bundles leave in arrival order. No duplication. No loss except by flush.
- Assertions (sim only):
  - in_fire never occurs in S_SKID.
  - out_data is stable while out_any & !out_ready.

Decomposition:
- pipe_pkg holds:
  - typedef enum logic [1:0] skid_state_t {S_EMPTY, S_FULL, S_SKID}.
  - localparam OCC_W = 2.
- Stage payload structs (e.g. the WB bundle type) stay in CPU_Defines.svh. Stages pack them into WIDTH and unpack at the instance.
- Sub-module: pipe_slot, a single LANES×WIDTH register with load, clear and CLEAR_DATA masking, instantiated twice (head, skid). The FSM stays in pipe_skid_reg.

Test Plan:
- Reset: rst = 1 for 2 cycles with in_valid = 2'b11 → out_valid = 0, out_data = 0, occ = 0, in_ready = 1; first bundle after release appears 1 cycle later.
- Streaming: out_ready = 1, bundles A = {0x10, 0x11} … E each cycle → out_data equals input delayed by exactly 1 cycle; occ = 1 throughout; no bubbles.
- Backpressure: out_ready = 0, send A then B → occ = 2, in_ready = 0 in the cycle after B; C is held upstream. Raise out_ready → outputs A, B, C on consecutive cycles; in_ready = 1 one cycle after A leaves.
- Partial bundle: in_valid = 2'b01, lane1 data 0xDEADBEEF, CLEAR_DATA = 1 → out_valid = 2'b01, lane1 out_data = 0. With CLEAR_DATA = 0, lane1 = 0xDEADBEEF.
- Flush in S_SKID with a new bundle on input → next cycle occ = 0, out_valid = 0, in_ready = 1; the flushed bundle and all held bundles never appear on the output.
- Simultaneous rst and flush with in_valid = 2'b11 and out_ready = 0 → reset values; no later spurious output.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stage registers.
// Combinational definitions only: no latency and no handshake of its own.
package pipe_pkg;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FULL  = 2'd1,
        S_SKID  = 2'd2
    } skid_state_t;

    localparam int OCC_W = 2;

endpackage

// File: rtl/pipe_slot.sv
// One LANES x WIDTH bundle register with load, clear and invalid-lane masking.
// Captures on the next edge after load; no flow control of its own (priority: rst > clr > load).
module pipe_slot #(
    parameter int WIDTH      = 32,
    parameter int LANES      = 2,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   load,
    input  logic [LANES-1:0]       d_valid,
    input  logic [LANES*WIDTH-1:0] d_data,
    output logic [LANES-1:0]       valid,
    output logic [LANES*WIDTH-1:0] data
);

    logic [LANES*WIDTH-1:0] masked;

    always_comb begin
        masked = d_data;
        if (CLEAR_DATA) begin
            for (int i = 0; i < LANES; i++) begin
                if (!d_valid[i]) masked[i*WIDTH +: WIDTH] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            data  <= '0;
        end else if (clr) begin
            valid <= '0;
            // With CLEAR_DATA = 0 the payload stays put so the clear costs no data-path enable
            if (CLEAR_DATA) data <= '0;
        end else if (load) begin
            valid <= d_valid;
            data  <= masked;
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Multi-lane stage register with valid/ready handshake and a 2-entry skid buffer.
// Latency 1 cycle; in_ready is registered, so a full bundle is accepted every cycle without a comb ready path.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int LANES      = 2,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [LANES-1:0]       in_valid,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic                   in_ready,
    output logic [LANES-1:0]       out_valid,
    output logic [LANES*WIDTH-1:0] out_data,
    input  logic                   out_ready,
    output logic [OCC_W-1:0]       occ
);

    skid_state_t state;

    logic in_any, in_fire, out_any, out_fire;
    logic head_load, head_clr, skid_load, skid_clr;
    logic [LANES-1:0]       skid_valid, head_src_valid;
    logic [LANES*WIDTH-1:0] skid_data, head_src_data;

    assign in_any   = |in_valid;
    assign in_fire  = in_any & in_ready;
    assign out_any  = |out_valid;
    assign out_fire = out_any & out_ready;

    // Head refills from the skid slot on resume, otherwise straight from the input
    assign head_src_valid = (state == S_SKID) ? skid_valid : in_valid;
    assign head_src_data  = (state == S_SKID) ? skid_data  : in_data;

    assign head_load = (in_fire & ((state == S_EMPTY) | ((state == S_FULL) & out_fire)))
                     | ((state == S_SKID) & out_fire);
    assign head_clr  = flush | ((state == S_FULL) & ~in_fire & out_fire);
    assign skid_load = (state == S_FULL) & in_fire & ~out_fire;
    assign skid_clr  = flush | ((state == S_SKID) & out_fire);

    pipe_slot #(.WIDTH(WIDTH), .LANES(LANES), .CLEAR_DATA(CLEAR_DATA)) u_head (
        .clk     (clk),
        .rst     (rst),
        .clr     (head_clr),
        .load    (head_load),
        .d_valid (head_src_valid),
        .d_data  (head_src_data),
        .valid   (out_valid),
        .data    (out_data)
    );

    pipe_slot #(.WIDTH(WIDTH), .LANES(LANES), .CLEAR_DATA(CLEAR_DATA)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .clr     (skid_clr),
        .load    (skid_load),
        .d_valid (in_valid),
        .d_data  (in_data),
        .valid   (skid_valid),
        .data    (skid_data)
    );

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state    <= S_EMPTY;
            in_ready <= 1'b1;
            occ      <= OCC_W'(0);
        end else begin
            case (state)
                S_EMPTY: begin
                    if (in_fire) begin
                        state <= S_FULL;
                        occ   <= OCC_W'(1);
                    end
                end
                S_FULL: begin
                    if (in_fire && !out_fire) begin
                        state    <= S_SKID;
                        in_ready <= 1'b0;
                        occ      <= OCC_W'(2);
                    end else if (!in_fire && out_fire) begin
                        state <= S_EMPTY;
                        occ   <= OCC_W'(0);
                    end
                end
                S_SKID: begin
                    if (out_fire) begin
                        state    <= S_FULL;
                        in_ready <= 1'b1;
                        occ      <= OCC_W'(1);
                    end
                end
                default: begin
                    state    <= S_EMPTY;
                    in_ready <= 1'b1;
                    occ      <= OCC_W'(0);
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    logic                   stall_q;
    logic [LANES*WIDTH-1:0] held_q;

    always_ff @(posedge clk) begin
        assert (!(in_fire && state == S_SKID))
            else $error("pipe_skid_reg: input accepted while skid slot occupied");
        if (stall_q) begin
            assert (out_data == held_q)
                else $error("pipe_skid_reg: out_data changed while stalled");
        end
        stall_q <= !rst && !flush && out_any && !out_ready;
        held_q  <= out_data;
    end
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench: two instances (CLEAR_DATA 1 and 0) on shared stimulus, checked against a depth-2 FIFO model.
module tb_pipe_skid_reg;

    localparam int W = 32;
    localparam int L = 2;

    logic           clk = 1'b0;
    logic           rst, flush, out_ready;
    logic [L-1:0]   in_valid;
    logic [L*W-1:0] in_data;

    logic           rdy_c, rdy_r;
    logic [L-1:0]   ov_c, ov_r;
    logic [L*W-1:0] od_c, od_r;
    logic [1:0]     occ_c, occ_r;

    always #5 clk = ~clk;

    pipe_skid_reg #(.WIDTH(W), .LANES(L), .CLEAR_DATA(1'b1)) dut_clr (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_c), .out_valid(ov_c), .out_data(od_c), .out_ready(out_ready), .occ(occ_c)
    );

    pipe_skid_reg #(.WIDTH(W), .LANES(L), .CLEAR_DATA(1'b0)) dut_raw (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_r), .out_valid(ov_r), .out_data(od_r), .out_ready(out_ready), .occ(occ_r)
    );

    typedef struct {
        logic [L-1:0]   v;
        logic [L*W-1:0] d;
    } bundle_t;

    bundle_t q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    function automatic logic [L*W-1:0] masked(bundle_t b);
        logic [L*W-1:0] r = b.d;
        for (int i = 0; i < L; i++) if (!b.v[i]) r[i*W +: W] = '0;
        return r;
    endfunction

    task automatic chk(string tag, logic [L*W-1:0] obs, logic [L*W-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: a FIFO of at most two bundles; ready whenever it has room.
    task automatic model_edge();
        int  sz   = q.size();
        bit  inf  = (|in_valid) && (sz < 2);
        bit  outf = (sz > 0) && out_ready;
        bundle_t b;
        if (rst || flush) q.delete();
        else begin
            if (outf) void'(q.pop_front());
            if (inf) begin
                b.v = in_valid;
                b.d = in_data;
                q.push_back(b);
            end
        end
    endtask

    task automatic check_all(string tag);
        logic [L-1:0]   ev;
        logic [L*W-1:0] ed;
        ev = (q.size() > 0) ? q[0].v : '0;
        ed = (q.size() > 0) ? masked(q[0]) : '0;
        chk({tag, ".valid_c"}, L*W'(ov_c), L*W'(ev));
        chk({tag, ".data_c"},  od_c, ed);
        chk({tag, ".occ_c"},   L*W'(occ_c), L*W'(q.size()));
        chk({tag, ".rdy_c"},   L*W'(rdy_c), L*W'(q.size() < 2));
        chk({tag, ".valid_r"}, L*W'(ov_r), L*W'(ev));
        chk({tag, ".occ_r"},   L*W'(occ_r), L*W'(q.size()));
        chk({tag, ".rdy_r"},   L*W'(rdy_r), L*W'(q.size() < 2));
        if (q.size() > 0) chk({tag, ".data_r"}, od_r, q[0].d);
    endtask

    task automatic step(string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic drive(logic [L-1:0] v, logic [W-1:0] l1, logic [W-1:0] l0);
        in_valid = v;
        in_data  = {l1, l0};
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(2'b11, 32'hAAAA_0001, 32'hAAAA_0000);

        // Reset holds everything empty despite valid input
        step("rst0");
        step("rst1");
        chk("rst.occ", 64'(occ_c), 64'd0);
        chk("rst.data", od_c, 64'd0);

        // First bundle after release appears one cycle later
        rst = 1'b0;
        drive(2'b11, 32'h11, 32'h10);
        step("first");
        chk("first.data", od_c, {32'h11, 32'h10});

        // Streaming with out_ready high: one bundle per cycle, occ stays 1
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            drive(2'b11, 32'h11 + 32'(i*16), 32'h10 + 32'(i*16));
            step("stream");
            chk("stream.occ", 64'(occ_c), 64'd1);
        end
        drive(2'b00, 32'h0, 32'h0);
        step("drain");

        // Backpressure: A, B fill both slots, C waits upstream
        out_ready = 1'b0;
        drive(2'b11, 32'hA1, 32'hA0); step("bp.a");
        drive(2'b11, 32'hB1, 32'hB0); step("bp.b");
        chk("bp.occ2", 64'(occ_c), 64'd2);
        chk("bp.rdy0", 64'(rdy_c), 64'd0);
        drive(2'b11, 32'hC1, 32'hC0); step("bp.c_wait");
        step("bp.c_wait2");
        out_ready = 1'b1;
        step("bp.a_out");
        chk("bp.b_head", od_c, {32'hB1, 32'hB0});
        chk("bp.rdy1", 64'(rdy_c), 64'd1);
        step("bp.c_in");
        chk("bp.c_head", od_c, {32'hC1, 32'hC0});
        drive(2'b00, 32'h0, 32'h0);
        step("bp.drain");

        // Partial bundle: lane 1 payload is zeroed only when CLEAR_DATA is set
        drive(2'b01, 32'hDEAD_BEEF, 32'h1234_5678);
        step("partial");
        chk("partial.lane1_c", 64'(od_c[W +: W]), 64'd0);
        chk("partial.lane1_r", 64'(od_r[W +: W]), 64'hDEAD_BEEF);
        drive(2'b00, 32'h0, 32'h0);
        step("partial.drain");

        // Flush while in S_SKID with a fresh bundle on the input
        out_ready = 1'b0;
        drive(2'b11, 32'hE1, 32'hE0); step("fl.a");
        drive(2'b10, 32'hF1, 32'hF0); step("fl.b");
        drive(2'b11, 32'h71, 32'h70);
        flush = 1'b1;
        step("fl.cycle");
        chk("fl.occ", 64'(occ_c), 64'd0);
        chk("fl.data_c", od_c, 64'd0);
        flush = 1'b0; out_ready = 1'b1;
        drive(2'b00, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) step("fl.after");

        // Simultaneous rst and flush with a full stage and valid input
        out_ready = 1'b0;
        drive(2'b11, 32'h91, 32'h90); step("rf.a");
        drive(2'b11, 32'h93, 32'h92); step("rf.b");
        rst = 1'b1; flush = 1'b1;
        step("rf.cycle");
        chk("rf.occ", 64'(occ_c), 64'd0);
        rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(2'b00, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) step("rf.after");

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            flush     = ($urandom_range(0, 24) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            drive(2'($urandom_range(0, 3)), $urandom, $urandom);
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
